// File: rtl/search_arb.sv
// search_arb: round-robin arbiter/sequencer sharing one search RAM lookup port among C_NUM_REQ key sources.
// Optional search watchdog: define SEARCH_ARB_TIMEOUT_EN to abandon searches after C_TIMEOUT WAIT cycles.
module search_arb #(
    parameter int C_NUM_REQ    = 4,
    parameter int C_RULE_WIDTH = 24,
    parameter int C_ADDR_WIDTH = 8,
    parameter int C_TIMEOUT    = 15
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [C_NUM_REQ-1:0]              req_i,
    input  logic [C_NUM_REQ*C_RULE_WIDTH-1:0] key_i,
    output logic [C_NUM_REQ-1:0]              ack_o,
    output logic                              search_o,
    output logic [C_RULE_WIDTH-1:0]           key_o,
    input  logic                              done_i,
    input  logic                              hit_i,
    input  logic [C_ADDR_WIDTH-1:0]           addr_i,
    output logic [C_NUM_REQ-1:0]              resp_vld_o,
    output logic                              resp_hit_o,
    output logic [C_ADDR_WIDTH-1:0]           resp_addr_o,
    output logic                              timeout_o,
    output logic                              busy_o
);
    localparam int PTR_W = $clog2(C_NUM_REQ);

    if (C_NUM_REQ < 2 || C_NUM_REQ > 8) begin : g_bad_num_req
        $error("search_arb: C_NUM_REQ must be 2..8");
    end
    if (C_TIMEOUT < 1 || C_TIMEOUT > 255) begin : g_bad_timeout
        $error("search_arb: C_TIMEOUT must be 1..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [PTR_W-1:0]        ptr;
    logic [PTR_W-1:0]        ptr_nxt;
    logic [PTR_W-1:0]        owner;
    logic [PTR_W-1:0]        owner_nxt;
    logic [PTR_W-1:0]        sel;
    logic                    sel_vld;
    logic                    timeout_hit;
    logic [C_RULE_WIDTH-1:0] keys [C_NUM_REQ];

    logic [C_NUM_REQ-1:0]    ack_nxt;
    logic                    search_nxt;
    logic [C_RULE_WIDTH-1:0] key_nxt;
    logic [C_NUM_REQ-1:0]    resp_vld_nxt;
    logic                    resp_hit_nxt;
    logic [C_ADDR_WIDTH-1:0] resp_addr_nxt;
    logic                    busy_nxt;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
        logic [PTR_W:0] nxt;
        nxt = {1'b0, idx} + (PTR_W+1)'(1);
        if (nxt == (PTR_W+1)'(C_NUM_REQ))
            nxt = '0;
        return nxt[PTR_W-1:0];
    endfunction

    always_comb begin
        for (int k = 0; k < C_NUM_REQ; k++)
            keys[k] = key_i[k*C_RULE_WIDTH +: C_RULE_WIDTH];
    end

    // Scan from the farthest slot back toward the pointer so the nearest request wins.
    always_comb begin
        logic [PTR_W:0] sum;
        sel     = ptr;
        sel_vld = 1'b0;
        sum     = '0;
        for (int i = C_NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(C_NUM_REQ))
                sum = sum - (PTR_W+1)'(C_NUM_REQ);
            if (req_i[sum[PTR_W-1:0]]) begin
                sel     = sum[PTR_W-1:0];
                sel_vld = 1'b1;
            end
        end
    end

`ifdef SEARCH_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       timeout_reg;

    // Counter is zeroed on the ISSUE->WAIT edge, so it holds the number of completed WAIT cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= timeout_hit;
            if (state == ISSUE)
                wait_cnt <= '0;
            else if (state == WAIT)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign timeout_hit = (state == WAIT) && !done_i && (wait_cnt == 8'(C_TIMEOUT - 1));
    assign timeout_o   = timeout_reg;
`else
    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (done_i || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack_nxt       = '0;
        search_nxt    = 1'b0;
        key_nxt       = key_o;
        resp_vld_nxt  = '0;
        resp_hit_nxt  = resp_hit_o;
        resp_addr_nxt = resp_addr_o;
        owner_nxt     = owner;
        ptr_nxt       = ptr;
        busy_nxt      = (state_nxt == ISSUE) || (state_nxt == WAIT);
        case (state)
            IDLE: begin
                if (sel_vld) begin
                    owner_nxt  = sel;
                    ptr_nxt    = next_idx(sel);
                    key_nxt    = keys[sel];
                    ack_nxt    = C_NUM_REQ'(1) << sel;
                    search_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (done_i) begin
                    resp_vld_nxt  = C_NUM_REQ'(1) << owner;
                    resp_hit_nxt  = hit_i;
                    resp_addr_nxt = addr_i;
                end else if (timeout_hit) begin
                    resp_vld_nxt  = C_NUM_REQ'(1) << owner;
                    resp_hit_nxt  = 1'b0;
                    resp_addr_nxt = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr         <= '0;
            owner       <= '0;
            ack_o       <= '0;
            search_o    <= 1'b0;
            key_o       <= '0;
            resp_vld_o  <= '0;
            resp_hit_o  <= 1'b0;
            resp_addr_o <= '0;
            busy_o      <= 1'b0;
        end else begin
            ptr         <= ptr_nxt;
            owner       <= owner_nxt;
            ack_o       <= ack_nxt;
            search_o    <= search_nxt;
            key_o       <= key_nxt;
            resp_vld_o  <= resp_vld_nxt;
            resp_hit_o  <= resp_hit_nxt;
            resp_addr_o <= resp_addr_nxt;
            busy_o      <= busy_nxt;
        end
    end
endmodule
